// File: rtl/led_pattern_monitor.sv
// led_pattern_monitor: tracks a one-hot light bus that walks across 8 LEDs.
// The bus is synchronised, decoded to an index and classified as an adjacent
// step, a non-adjacent jump, a stall (no movement) or an illegal pattern.
// Optional feature macro: LED_MON_STEPCNT_EN enables the step_cnt register;
// without it step_cnt is tied to zero.
module led_pattern_monitor #(
    parameter int sim = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] led,
    output logic [2:0] pos,
    output logic       dir,
    output logic       valid,
    output logic       step,
    output logic       jump,
    output logic       stall,
    output logic [7:0] step_cnt
);

    localparam int CW = sim ? 4 : 27;
    localparam logic [CW-1:0] STALL_N = CW'(sim ? 15 : 75_000_000);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOCK = 2'd1,
        BAD  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    s1;
    logic [7:0]    s2;
    logic [7:0]    prev;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] stall_cnt_next;
    logic [2:0]    pos_next;
    logic          dir_next;
    logic          step_next;
    logic          jump_next;
    logic [2:0]    idx;
    logic          legal;
    logic          up_move;
    logic          down_move;

    // Two-flop synchroniser for the asynchronous bus plus the previous sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= 8'h00;
            s2   <= 8'h00;
            prev <= 8'h00;
        end else begin
            s1   <= led;
            s2   <= s1;
            prev <= s2;
        end
    end

    // Decode the synchronised sample into a bit index and adjacency flags.
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (s2[i]) idx = i[2:0];
        end
        legal     = $onehot(s2);
        up_move   = (idx == 3'(pos + 3'd1));
        down_move = (idx == 3'(pos - 3'd1));
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and next-output logic; IDLE and BAD both relock on a legal pattern.
    always_comb begin
        state_next     = state;
        pos_next       = pos;
        dir_next       = dir;
        step_next      = 1'b0;
        jump_next      = 1'b0;
        stall_cnt_next = stall_cnt;
        case (state)
            IDLE, BAD: begin
                stall_cnt_next = '0;
                if (legal) begin
                    state_next = LOCK;
                    pos_next   = idx;
                end
            end
            LOCK: begin
                if (s2 == prev) begin
                    if (stall_cnt != STALL_N) stall_cnt_next = stall_cnt + 1'b1;
                end else if (!legal) begin
                    state_next     = BAD;
                    stall_cnt_next = '0;
                end else begin
                    stall_cnt_next = '0;
                    pos_next       = idx;
                    if (up_move) begin
                        step_next = 1'b1;
                        dir_next  = 1'b1;
                    end else if (down_move) begin
                        step_next = 1'b1;
                        dir_next  = 1'b0;
                    end else if (idx != pos) begin
                        jump_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next     = IDLE;
                stall_cnt_next = '0;
            end
        endcase
    end

    // Registered tracking outputs and the stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos       <= 3'd0;
            dir       <= 1'b1;
            step      <= 1'b0;
            jump      <= 1'b0;
            stall_cnt <= '0;
        end else begin
            pos       <= pos_next;
            dir       <= dir_next;
            step      <= step_next;
            jump      <= jump_next;
            stall_cnt <= stall_cnt_next;
        end
    end

    assign valid = (state == LOCK);
    assign stall = (state == LOCK) && (stall_cnt == STALL_N);

`ifdef LED_MON_STEPCNT_EN
    logic [7:0] step_cnt_q;

    // Count adjacent steps, wrapping naturally at 8 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          step_cnt_q <= 8'h00;
        else if (step_next) step_cnt_q <= step_cnt_q + 8'd1;
    end

    assign step_cnt = step_cnt_q;
`else
    assign step_cnt = 8'h00;
`endif

endmodule
